// File: rtl/hash_pad_pkg.sv
// hash_pad_pkg: shared states, constants and word helpers for the hash block padder
package hash_pad_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        FILL,
        LEN_HI,
        LEN_LO,
        DONE
    } pad_state_t;

    localparam logic [7:0] PAD_BYTE    = 8'h80;
    localparam int         BLOCK_WORDS = 16;

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // keep the first r message bytes (from bit 31) and place the pad byte right after them
    function automatic logic [31:0] pad_word(input logic [31:0] w, input logic [1:0] r);
        logic [31:0] keep;
        keep = ~(32'hFFFF_FFFF >> {r, 3'b000});
        return (w & keep) | ({PAD_BYTE, 24'h0} >> {r, 3'b000});
    endfunction

endpackage

// File: rtl/hash_pad_fifo.sv
// hash_pad_fifo: small power-of-two FIFO buffering padded words towards the consumer
module hash_pad_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 37
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;

    assign dout  = mem[rp];
    assign empty = (count == '0);

    // storage array, no reset needed since empty gates every read
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= din;
    end

    // pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + AW'(1);
            if (pop) rp <= rp + AW'(1);
            count <= count + ($clog2(DEPTH)+1)'(push) - ($clog2(DEPTH)+1)'(pop);
        end
    end

endmodule

// File: rtl/hash_block_padder.sv
// hash_block_padder: streams a memory message as padded 512-bit hash blocks (HASH_PAD_BSWAP_EN byte-swaps memory words)
module hash_block_padder
    import hash_pad_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int SIZE_W     = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] message_addr,
    input  logic [SIZE_W-1:0] size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [31:0]       mem_read_data,
    output logic [31:0]       blk_word,
    output logic              blk_valid,
    input  logic              blk_ready,
    output logic [3:0]        blk_idx,
    output logic              blk_last,
    output logic              busy,
    output logic              done
);

    localparam int KW = SIZE_W + 5;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    pad_state_t        state, state_n;
    logic [ADDR_W-1:0] addr_q;
    logic [SIZE_W-1:0] size_q;
    logic [KW-1:0]     k, k_n, rd_idx, total, nr, pad_k;
    logic [SIZE_W:0]   blocks, nreads;
    logic              rd_pending, room, pop, push, gen_push, gen_last;
    logic [31:0]       gen_word, rd_raw, rd_word;
    logic [36:0]       din, dout;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;

    assign blocks = (({1'b0, size_q} + (SIZE_W+1)'(8)) >> 6) + (SIZE_W+1)'(1);
    assign nreads = ({1'b0, size_q} + (SIZE_W+1)'(3)) >> 2;
    assign total  = KW'(blocks) << 4;
    assign nr     = KW'(nreads);
    assign pad_k  = KW'(size_q >> 2);

`ifdef HASH_PAD_BSWAP_EN
    assign rd_raw = bswap32(mem_read_data);
`else
    assign rd_raw = mem_read_data;
`endif

    assign rd_word = (rd_idx == pad_k) ? pad_word(rd_raw, size_q[1:0]) : rd_raw;

    // a returning read already owns a slot, so room counts it alongside the stored words
    assign pop  = !fifo_empty && blk_ready;
    assign room = (32'(fifo_count) + 32'(rd_pending)) < (32'(FIFO_DEPTH) + 32'(pop));

    assign push = rd_pending | gen_push;
    assign din  = rd_pending ? {rd_word, rd_idx[3:0], 1'b0} : {gen_word, k[3:0], gen_last};

    assign blk_valid = !fifo_empty;
    assign {blk_word, blk_idx, blk_last} = fifo_empty ? 37'h0 : dout;
    assign busy     = (state != IDLE);
    assign mem_addr = mem_rd ? addr_q + ADDR_W'(k) : '0;

    // next-state, read issue and generated-word selection
    always_comb begin
        state_n  = state;
        k_n      = k;
        mem_rd   = 1'b0;
        gen_push = 1'b0;
        gen_word = 32'h0;
        gen_last = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                k_n = '0;
                if (start) state_n = FETCH;
            end
            FETCH: begin
                if (k >= nr) begin
                    state_n = (k == total - KW'(2)) ? LEN_HI : FILL;
                end else if (room) begin
                    mem_rd = 1'b1;
                    k_n    = k + KW'(1);
                    if (k_n == nr) state_n = (k_n == total - KW'(2)) ? LEN_HI : FILL;
                end
            end
            FILL: begin
                if (room && !rd_pending) begin
                    gen_push = 1'b1;
                    gen_word = (k == pad_k) ? {PAD_BYTE, 24'h0} : 32'h0;
                    k_n      = k + KW'(1);
                    if (k == total - KW'(3)) state_n = LEN_HI;
                end
            end
            LEN_HI: begin
                if (room && !rd_pending) begin
                    gen_push = 1'b1;
                    gen_word = 32'(size_q >> 29);
                    k_n      = k + KW'(1);
                    state_n  = LEN_LO;
                end
            end
            LEN_LO: begin
                if (k != total) begin
                    if (room && !rd_pending) begin
                        gen_push = 1'b1;
                        gen_word = 32'({size_q, 3'b000});
                        gen_last = 1'b1;
                        k_n      = k + KW'(1);
                    end
                end else if (pop && dout[0]) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // state, word counter, job parameters and the one-deep read return tracker
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            k          <= '0;
            rd_pending <= 1'b0;
            rd_idx     <= '0;
            addr_q     <= '0;
            size_q     <= '0;
        end else begin
            state      <= state_n;
            k          <= k_n;
            rd_pending <= mem_rd;
            if (mem_rd) rd_idx <= k;
            if (state == IDLE && start) begin
                addr_q <= message_addr;
                size_q <= size;
            end
        end
    end

    hash_pad_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (37)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .dout  (dout),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_hash_block_padder.sv
// tb_hash_block_padder: scoreboard bench for hash_block_padder (HASH_PAD_BSWAP_EN selects the swapped expectation)
module tb_hash_block_padder;

    localparam int ADDR_W = 16;
    localparam int SIZE_W = 32;

    logic              clk = 1'b0;
    logic              reset, start, blk_ready;
    logic [ADDR_W-1:0] message_addr, mem_addr, base;
    logic [SIZE_W-1:0] size;
    logic              mem_rd, blk_valid, blk_last, busy, done;
    logic [31:0]       mem_read_data, blk_word, seed;
    logic [3:0]        blk_idx;
    logic [36:0]       exp_q [$];
    int                checks = 0;
    int                failures = 0;

    always #5 clk = ~clk;

    hash_block_padder dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .message_addr  (message_addr),
        .size          (size),
        .mem_addr      (mem_addr),
        .mem_rd        (mem_rd),
        .mem_read_data (mem_read_data),
        .blk_word      (blk_word),
        .blk_valid     (blk_valid),
        .blk_ready     (blk_ready),
        .blk_idx       (blk_idx),
        .blk_last      (blk_last),
        .busy          (busy),
        .done          (done)
    );

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        int s;
        s = n % 32;
        return (s == 0) ? v : ((v << s) | (v >> (32 - s)));
    endfunction

    // memory: word at base+i holds seed rotated left by i; garbage when not read
    always @(posedge clk)
        mem_read_data <= mem_rd ? rotl(seed, int'(ADDR_W'(mem_addr - base))) : 32'hDEAD_BEEF;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input longint s, input longint k);
        longint      total;
        logic [31:0] m, w;
        total = 16 * ((s + 8) / 64 + 1);
        m = rotl(seed, int'(k % 32));
`ifdef HASH_PAD_BSWAP_EN
        m = {m[7:0], m[15:8], m[23:16], m[31:24]};
`endif
        if (k < s / 4) return m;
        if (k == s / 4) begin
            w = 32'h0;
            for (int b = 0; b < 4; b++)
                w[31-8*b -: 8] = (b < s % 4) ? m[31-8*b -: 8] : (b == s % 4) ? 8'h80 : 8'h00;
            return w;
        end
        if (k == total - 2) return 32'(s >> 29);
        if (k == total - 1) return 32'(s << 3);
        return 32'h0;
    endfunction

    task automatic run_job(input longint s, input logic [ADDR_W-1:0] b, input logic [31:0] sd,
                           input int stall, input int abort_k, input string tag);
        longint total;
        int cyc, reads, dones, first, last;
        total = 16 * ((s + 8) / 64 + 1);
        seed  = sd;
        base  = b;
        exp_q.delete();
        for (longint k = 0; k < total; k++)
            exp_q.push_back({exp_word(s, k), 4'(k % 16), k == total - 1});
        @(negedge clk);
        start        = 1'b1;
        message_addr = b;
        size         = SIZE_W'(s);
        blk_ready    = 1'b0;
        cyc = 0; reads = 0; dones = 0; first = -1; last = -1;
        while (cyc < 5000 && !(dones == 1 && !busy)) begin
            @(negedge clk);
            cyc++;
            blk_ready = ($urandom_range(99) >= stall);
            start     = (stall > 0 && cyc == 20);
            if (start) begin
                size         = 5;
                message_addr = b + 16'h40;
            end
            #1;
            if (abort_k >= 0 && blk_valid && blk_idx == 4'(abort_k)) begin
                reset = 1'b1;
                @(negedge clk);
                #1;
                check({tag, "_reset_outputs"},
                      64'({busy, done, blk_valid, mem_rd, mem_addr, blk_idx, blk_last, blk_word}), 64'h0);
                reset = 1'b0;
                exp_q.delete();
                return;
            end
            if (mem_rd) reads++;
            if (done) begin
                dones++;
                check({tag, "_done_timing"}, 64'(cyc - last), 64'd1);
            end
            if (blk_valid) begin
                if (exp_q.size() == 0) check({tag, "_extra_word"}, 64'(blk_word), 64'hFFFF_FFFF_FFFF_FFFF);
                else check({tag, "_word"}, 64'({blk_word, blk_idx, blk_last}), 64'(exp_q[0]));
                if (blk_ready) begin
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    if (first < 0) first = cyc;
                    last = cyc;
                end
            end
        end
        check({tag, "_timeout"}, 64'(cyc >= 5000), 64'd0);
        check({tag, "_words_left"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_reads"}, 64'(reads), 64'((s + 3) / 4));
        check({tag, "_done_count"}, 64'(dones), 64'd1);
        check({tag, "_busy_after"}, 64'(busy), 64'd0);
        if (stall == 0) check({tag, "_throughput"}, 64'(last - first), 64'(total - 1));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; blk_ready = 1'b0;
        message_addr = '0; size = '0; seed = '0; base = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_state", 64'({busy, done, blk_valid, mem_rd, mem_addr, blk_idx, blk_last, blk_word}), 64'h0);
        reset = 1'b0;
        run_job(0,   16'h0100, 32'h0123_4567, 0,  -1, "size0");
        run_job(120, 16'h0200, 32'h0123_4567, 0,  -1, "size120");
        run_job(55,  16'h0300, 32'hA5C3_0F96, 0,  -1, "size55");
        run_job(56,  16'h0300, 32'hA5C3_0F96, 0,  -1, "size56");
        run_job(1,   16'h0400, 32'h0123_4567, 0,  -1, "size1");
        run_job(120, 16'hFFF8, 32'h0123_4567, 40, -1, "stall120_wrap");
        run_job(3,   16'h0500, 32'hCAFE_F00D, 50, -1, "stall3");
        run_job(64,  16'h0600, 32'h1357_9BDF, 30, -1, "stall64");
        run_job(201, 16'h0700, 32'h8421_0F0F, 20, -1, "stall201");
        run_job(100, 16'h0800, 32'h0BAD_F00D, 0,  7,  "abort100");
        run_job(100, 16'h0800, 32'h0BAD_F00D, 0,  -1, "rerun100");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hash_block_padder.md
HASH_BLOCK_PADDER -- requirements
Module: hash_block_padder

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, width of the memory word address.
REQ-002 SHALL have parameter SIZE_W, default 32, width of the message byte count; legal range 4..61.
REQ-003 SHALL have parameter FIFO_DEPTH, default 2, output word buffer entries (power of 2, at least 2).
REQ-004 SHALL have port clk  in  1  sole clock; all state changes on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port start  in  1  begin a job; sampled only in IDLE.
REQ-007 SHALL have port message_addr  in  ADDR_W  word address of message byte 0, latched at start.
REQ-008 SHALL have port size  in  SIZE_W  message length in bytes, latched at start.
REQ-009 SHALL have port mem_addr  out  ADDR_W  memory read address.
REQ-010 SHALL have port mem_rd  out  1  read strobe; data returns on mem_read_data exactly one cycle later.
REQ-011 SHALL have port mem_read_data  in  32  memory read data.
REQ-012 SHALL have port blk_word  out  32  padded message word.
REQ-013 SHALL have port blk_valid / blk_ready  out / in  1 / 1  word handshake; transfer when both are high.
REQ-014 SHALL have port blk_idx  out  4  word index 0..15 within the current 512-bit block.
REQ-015 SHALL have port blk_last  out  1  high with the final word of the final block.
REQ-016 SHALL have port busy / done  out / out  1 / 1  job active / one-cycle completion pulse.

Function
REQ-017 SHALL use states IDLE, FETCH, FILL, LEN_HI, LEN_LO, DONE; start in IDLE moves to FETCH; start in any other state is ignored.
REQ-018 SHALL compute blocks N = (size+8)/64 + 1 with SIZE_W+1-bit arithmetic and emit exactly 16*N words, in order k = 0..16N-1.
REQ-019 SHALL output memory word k (address message_addr+k, wrapping modulo 2^ADDR_W) for k < size/4.
REQ-020 SHALL output word k = size/4 as the memory word masked to its first size%4 bytes, counted from bit 31, with 0x80 in the next byte; when size%4 = 0 it SHALL be 0x80000000 and no read is issued.
REQ-021 SHALL output zero for the words between that word and word 16N-2; word 16N-2 = size>>29, word 16N-1 = (size<<3) truncated to 32 bits.
REQ-022 SHALL issue a read only when the FIFO has room for the returning word, and SHALL never read beyond word (size-1)/4.
REQ-023 SHALL hold blk_word/blk_idx/blk_last stable while blk_valid is high and blk_ready is low.
REQ-024 SHALL sustain one word per cycle while blk_ready is held high after the first word, given FIFO_DEPTH at least 2.
REQ-025 SHALL pulse done in the cycle after the blk_last transfer, then return to IDLE with busy low.

Reset
REQ-026 SHALL drive, on reset and in any state: state=IDLE, busy=0, done=0, blk_valid=0, mem_rd=0, mem_addr=0, blk_idx=0, blk_last=0, blk_word=0, FIFO empty; any in-flight read is discarded.

Configuration
REQ-027 SHALL byte-reverse every memory word before masking, {b[7:0],b[15:8],b[23:16],b[31:24]}, when HASH_PAD_BSWAP_EN is defined; when it is undefined, words SHALL pass unchanged; length words are never swapped.

Structure
REQ-028 SHALL place the state enum, PAD_BYTE=8'h80, BLOCK_WORDS=16 and the byte-swap function in package hash_pad_pkg.
REQ-029 SHALL implement the output buffer as sub-module hash_pad_fifo, parameterised by FIFO_DEPTH.

Verification
REQ-030 Test size=0: one block; word0=0x80000000, words 1..15 = 0; done pulses once.
REQ-031 Test size=120, seed 0x01234567 with each following word = rotl1 of the previous, blk_ready held high: 48 words; words 0..29 = memory; word30 = 0x80000000; word46 = 0; word47 = 0x3C0; blk_last on word47; 30 reads.
REQ-032 Test size=55 and size=56: 55 gives 1 block with word13 = top 3 bytes|0x80 and word15 = 0x1B8; 56 gives 2 blocks with word14 = 0x80000000 and word31 = 0x1C0.
REQ-033 Test size=1, mem word 0x01234567: word0 = 0x01800000 without the macro, 0x67800000 with HASH_PAD_BSWAP_EN.
REQ-034 Test random blk_ready stalls: word sequence identical to the stall-free run and outputs stable during stalls; start pulsed while busy has no effect.
REQ-035 Test reset asserted mid-block at k=7: next cycle all outputs at reset values; a new start then produces the full sequence from k=0.
